// File: rtl/mc_add_sub.sv
// mc_add_sub: chunk-serial adder/subtractor for WIDTH+1-bit operands.
// Processes CHUNK bits per clock, rippling the carry through a register, and
// answers the start_add_sub/done_add handshake of the field-inversion
// controller. Subtraction is a + ~b + 1, with the +1 entering as the initial
// carry.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   start_add_sub in   request strobe (accepted in IDLE or DONE)
//   a_i           in   WIDTH+1 first operand / minuend
//   b_i           in   WIDTH+1 second operand / subtrahend
//   add_sub_sel   in   1 = a_i - b_i, 0 = a_i + b_i
//   done_add      out  one-cycle completion pulse
//   s_o           out  WIDTH+1 result
//   c_o           out  carry out of bit WIDTH (1 = no borrow when subtracting)
//   busy          out  high while a computation is in progress
module mc_add_sub #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_add_sub,
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH:0]   b_i,
  input  logic             add_sub_sel,
  output logic             done_add,
  output logic [WIDTH:0]   s_o,
  output logic             c_o,
  output logic             busy
);

  localparam int W1     = WIDTH + 1;
  localparam int NCH    = (W1 + CHUNK - 1) / CHUNK;
  // Width of the final (possibly partial) chunk; its carry sits at this bit.
  localparam int LAST_W = W1 - (NCH - 1) * CHUNK;
  localparam int CW     = (NCH > 1) ? $clog2(NCH + 1) : 1;
  localparam int IW     = $clog2(W1 + CHUNK);
  localparam logic [CW-1:0] LAST_K = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [W1-1:0]   a_q, b_q, s_q;
  logic            sel_q, carry_q, c_q;
  logic [CW-1:0]   k_q;
  logic            accept, last;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]  ch_sum;
  logic            ch_cout;
  int              idx;

  assign accept = start_add_sub && (state != CALC);
  assign last   = (k_q == LAST_K);

  // Select chunk k of the latched operands. Bits beyond WIDTH read as zero
  // (not inverted) so the carry out of bit WIDTH lands at ch_sum[LAST_W].
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    idx  = 0;
    for (int j = 0; j < CHUNK; j++) begin
      idx = int'(k_q) * CHUNK + j;
      if (idx < W1) begin
        a_ch[j] = a_q[idx[IW-1:0]];
        b_ch[j] = b_q[idx[IW-1:0]] ^ sel_q;
      end
    end
  end

  assign ch_sum  = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
  assign ch_cout = last ? ch_sum[LAST_W] : ch_sum[CHUNK];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_add_sub) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = start_add_sub ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      carry_q <= 1'b0;
      k_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else if (accept) begin
      a_q     <= a_i;
      b_q     <= b_i;
      sel_q   <= add_sub_sel;
      carry_q <= add_sub_sel;
      k_q     <= '0;
    end else if (state == CALC) begin
      for (int i = 0; i < W1; i++) begin
        if (i / CHUNK == int'(k_q)) s_q[i] <= ch_sum[i % CHUNK];
      end
      carry_q <= ch_cout;
      k_q     <= k_q + CW'(1);
      if (last) c_q <= ch_cout;
    end
  end

  assign done_add = (state == DONE);
  assign busy     = (state == CALC);
  assign s_o      = s_q;
  assign c_o      = c_q;

endmodule

// File: tb/tb_mc_add_sub.sv
module tb_mc_add_sub;
  localparam int WIDTH = 256;
  localparam int CHUNK = 64;
  localparam int W1    = WIDTH + 1;
  localparam int NCH   = (W1 + CHUNK - 1) / CHUNK;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_add_sub;
  logic [W1-1:0] a_i, b_i, s_o;
  logic          add_sub_sel, done_add, c_o, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .reset(reset), .start_add_sub(start_add_sub),
    .a_i(a_i), .b_i(b_i), .add_sub_sel(add_sub_sel),
    .done_add(done_add), .s_o(s_o), .c_o(c_o), .busy(busy)
  );

  // Reference: plain modular arithmetic; c is overflow for add, (a >= b) for subtract.
  function automatic logic [W1:0] ref_op(input logic [W1-1:0] a, input logic [W1-1:0] b,
                                         input logic sel);
    logic [W1:0] r;
    if (!sel) begin
      r = {1'b0, a} + {1'b0, b};
    end else begin
      r[W1-1:0] = a - b;
      r[W1]     = (a >= b);
    end
    return r;
  endfunction

  function automatic logic [W1-1:0] rnd();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
    return t[W1-1:0];
  endfunction

  task automatic check(input string tag, input logic [W1-1:0] got, input logic [W1-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated request; operands are scrambled right after acceptance.
  task automatic run_op(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic sel,
                        input string tag);
    logic [W1:0] r;
    int n;
    int nbusy;
    r = ref_op(a, b, sel);
    @(negedge clk);
    a_i = a; b_i = b; add_sub_sel = sel; start_add_sub = 1'b1;
    @(negedge clk);
    start_add_sub = 1'b0; a_i = rnd(); b_i = rnd(); add_sub_sel = ~sel;
    n = 1; nbusy = 0;
    while (done_add !== 1'b1 && n < 20) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, W1'(n), W1'(NCH + 1));
    check({tag, " busy_cycles"}, W1'(nbusy), W1'(NCH));
    check({tag, " s_o"}, s_o, r[W1-1:0]);
    check({tag, " c_o"}, W1'(c_o), W1'(r[W1]));
    @(negedge clk);
    check({tag, " done_one_cycle"}, W1'(done_add), '0);
    check({tag, " s_o_hold"}, s_o, r[W1-1:0]);
  endtask

  logic [W1-1:0] p_val, ones256, ones257, sv;
  logic [W1-1:0] opa [4];
  logic [W1-1:0] opb [4];
  logic          ops [4];
  logic [W1:0]   r;
  int            n, dones, dn, idx;

  initial begin
    reset = 1'b1; start_add_sub = 1'b0; a_i = '0; b_i = '0; add_sub_sel = 1'b0;
    repeat (2) @(negedge clk);
    check("reset s_o", s_o, '0);
    check("reset c_o", W1'(c_o), '0);
    check("reset busy", W1'(busy), '0);
    check("reset done", W1'(done_add), '0);
    reset = 1'b0;

    ones257 = '1;
    ones256 = ones257 >> 1;
    p_val   = (W1'(1) << 256) - (W1'(1) << 32) - W1'(977);

    run_op(ones256, W1'(1), 1'b0, "ripple");
    check("ripple exact", s_o, W1'(1) << 256);
    run_op(ones257, W1'(1), 1'b0, "overflow");
    check("overflow exact", W1'(c_o), W1'(1));
    run_op(W1'(5), W1'(7), 1'b1, "sub5m7");
    check("sub5m7 exact", s_o, ones257 - W1'(1));
    run_op(W1'(7), W1'(5), 1'b1, "sub7m5");
    run_op(p_val, p_val, 1'b1, "subPmP");

    // Start while busy is ignored and a_i changes do not disturb the result.
    @(negedge clk);
    a_i = W1'(3); b_i = W1'(4); add_sub_sel = 1'b0; start_add_sub = 1'b1;
    @(negedge clk);
    start_add_sub = 1'b0;
    @(negedge clk);
    start_add_sub = 1'b1; a_i = W1'(100);
    @(negedge clk);
    start_add_sub = 1'b0;
    dones = 0; dn = 0; sv = '0;
    for (n = 3; n <= 12; n++) begin
      if (done_add === 1'b1) begin dones++; dn = n; sv = s_o; end
      @(negedge clk);
    end
    check("busy_start pulses", W1'(dones), W1'(1));
    check("busy_start latency", W1'(dn), W1'(NCH + 1));
    check("busy_start s_o", sv, W1'(7));

    // Reset in the middle of a subtraction.
    @(negedge clk);
    a_i = rnd(); b_i = rnd(); add_sub_sel = 1'b1; start_add_sub = 1'b1;
    @(negedge clk);
    start_add_sub = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset s_o", s_o, '0);
    check("midreset c_o", W1'(c_o), '0);
    check("midreset busy", W1'(busy), '0);
    check("midreset done", W1'(done_add), '0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (10) begin
      if (done_add === 1'b1) dones++;
      @(negedge clk);
    end
    check("midreset no_done", W1'(dones), '0);
    run_op(W1'(1000), W1'(1), 1'b1, "after_reset");

    // Back-to-back with start held high.
    for (int i = 0; i < 4; i++) begin
      opa[i] = rnd(); opb[i] = rnd(); ops[i] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    a_i = opa[0]; b_i = opb[0]; add_sub_sel = ops[0]; start_add_sub = 1'b1;
    idx = 0; n = 0;
    for (int cyc = 0; cyc < 60 && idx < 4; cyc++) begin
      @(negedge clk);
      n++;
      if (done_add === 1'b1) begin
        r = ref_op(opa[idx], opb[idx], ops[idx]);
        check("b2b period", W1'(n), W1'(NCH + 1));
        check("b2b s_o", s_o, r[W1-1:0]);
        check("b2b c_o", W1'(c_o), W1'(r[W1]));
        idx++;
        if (idx < 4) begin
          a_i = opa[idx]; b_i = opb[idx]; add_sub_sel = ops[idx];
        end else begin
          start_add_sub = 1'b0;
        end
        n = 0;
      end else begin
        a_i = rnd(); b_i = rnd(); add_sub_sel = 1'($urandom_range(0, 1));
      end
    end
    start_add_sub = 1'b0;
    check("b2b completed", W1'(idx), W1'(4));

    // Random operations.
    for (int i = 0; i < 20; i++) begin
      run_op(rnd(), rnd(), 1'($urandom_range(0, 1)), "random");
    end
    run_op(W1'(42), W1'(42), 1'b0, "small_add");
    run_op('0, ones257, 1'b1, "zero_minus_max");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
